// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter sharing one UART sender among N byte-producing requesters.
// Latency: accept edge -> tx_en high 1 cycle; sender idle sampled -> done 1 cycle later.
// Backpressure: req_ready is one-hot, only in IDLE with en=1 and sender idle; held low otherwise.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   en                        grant enable (does not affect a transfer in flight)
//   req_valid/req_data        per-requester byte offer (byte i on bits [8*i+7:8*i])
//   req_ready                 one-hot accept, combinational (no path from req_data)
//   tx_status/tx_en/tx_data   sender handshake (tx_status 1 = idle)
//   grant_id, busy, done, err, byte_count   status outputs
module tx_arbiter #(
  parameter int N             = 4,
  parameter int ID_WIDTH      = 2,
  parameter int START_TIMEOUT = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N-1:0]        req_valid,
  input  logic [8*N-1:0]      req_data,
  output logic [N-1:0]        req_ready,
  input  logic                tx_status,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         byte_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  logic [1:0]          state;
  logic [ID_WIDTH-1:0] last;
  logic [CW-1:0]       cnt;

  logic [ID_WIDTH-1:0] win;
  logic                found;
  logic                accept;
  int                  idx;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    win       = '0;
    found     = 1'b0;
    idx       = 0;
    req_ready = '0;
    if (state == IDLE && en && tx_status) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last) + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win   = ID_WIDTH'(idx);
        end
      end
      if (found) req_ready = N'(1) << win;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= ID_WIDTH'(N - 1);
      cnt        <= '0;
      tx_en      <= 1'b0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_count <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= req_data[8*win +: 8];
            grant_id <= win;
            last     <= win;
            tx_en    <= 1'b1;
            cnt      <= '0;
            state    <= START;
          end
        end
        START: begin
          if (!tx_status) begin
            tx_en <= 1'b0;
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            // Sender never picked the byte up: abandon it without counting.
            tx_en <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_status) begin
            done       <= 1'b1;
            byte_count <= byte_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: begin
          tx_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: self-checking bench for tx_arbiter with a sender model and a grant scoreboard.
// Latency: checks sampled 1 time unit after each rising clk edge.
// Backpressure: sender model drives tx_status busy after tx_en is seen for 4 cycles.
module tb_tx_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_status;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           done;
  logic           err;
  logic [15:0]    byte_count;

  always #5 clk = ~clk;

  tx_arbiter #(.N(N), .ID_WIDTH(IDW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_status(tx_status), .tx_en(tx_en), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy), .done(done), .err(err), .byte_count(byte_count)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_count = 16'h0000;
  int          sender_mode = 0;   // 0 = bench drives tx_status, 1 = auto sender, 2 = never busy
  int          busy_len = 100;

  // Sender model: goes busy once tx_en has been seen high on 4 samples, idle busy_len cycles later.
  initial begin
    int hi;
    hi = 0;
    forever begin
      @(posedge clk); #1;
      if (sender_mode == 1 && tx_en && !rst) begin
        hi++;
        if (hi == 4) begin
          hi = 0;
          tx_status = 1'b0;
          repeat (busy_len) @(posedge clk);
          #1;
          tx_status = 1'b1;
        end
      end else begin
        hi = 0;
      end
    end
  end

  // Scoreboard: each new tx_en assertion pops the expected grant; each done checks the count.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (tx_en && !prev_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected got id=%0d data=%h required no grant", grant_id, tx_data);
          end else begin
            e = exp_q.pop_front();
            if (grant_id !== e.id || tx_data !== e.data) begin
              errors++;
              $display("FAIL grant_order got id=%0d data=%h required id=%0d data=%h",
                       grant_id, tx_data, e.id, e.data);
            end
          end
        end
        if (done) begin
          model_count = model_count + 16'd1;
          checks++;
          if (byte_count !== model_count) begin
            errors++;
            $display("FAIL byte_count_on_done got %h required %h", byte_count, model_count);
          end
        end
        prev_en = tx_en;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req_valid = '0; tx_status = 1'b1; sender_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_count = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_valid = '0; req_data = '0; tx_status = 1'b1;
    #2;
    checks++; if (tx_en !== 1'b0)   begin errors++; $display("FAIL reset_tx_en got %b required 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h required 00", tx_data); end
    checks++; if (grant_id !== '0)  begin errors++; $display("FAIL reset_grant_id got %0d required 0", grant_id); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b err=%b required 0", busy, done, err); end
    checks++; if (byte_count !== 16'h0) begin errors++; $display("FAIL reset_byte_count got %h required 0", byte_count); end
    do_reset();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b required 0", req_ready); end
  endtask

  task automatic test_single();
    int rc, tc, n;
    bit got;
    do_reset();
    sender_mode = 1; busy_len = 100;
    req_data = 32'h0000_005A;
    exp_q.push_back('{id: 2'd0, data: 8'h5A});
    req_valid = 4'b0001;
    #1;
    rc = 0; tc = 0; n = 0; got = 0;
    while (!got && n < 400) begin
      if (req_ready[0]) rc++;
      if (tx_en) begin tc++; req_valid = '0; end
      if (done) got = 1;
      else begin @(posedge clk); #1; n++; end
    end
    checks++; if (!got)      begin errors++; $display("FAIL single_done got none required pulse"); end
    checks++; if (rc != 1)   begin errors++; $display("FAIL single_ready_cycles got %0d required 1", rc); end
    checks++; if (tc != 4)   begin errors++; $display("FAIL single_tx_en_cycles got %0d required 4", tc); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL single_tx_data got %h required 5a", tx_data); end
    checks++; if (byte_count !== 16'd1) begin errors++; $display("FAIL single_byte_count got %0d required 1", byte_count); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant_id got %0d required 0", grant_id); end
  endtask

  task automatic test_round_robin();
    int dc, n;
    do_reset();
    sender_mode = 1; busy_len = 5;
    req_data = 32'h1312_1110;
    for (int k = 0; k < 8; k++) exp_q.push_back('{id: IDW'(k % 4), data: 8'h10 + 8'(k % 4)});
    req_valid = 4'b1111;
    dc = 0; n = 0;
    while (dc < 8 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (done) dc++;
    end
    req_valid = '0;
    checks++; if (dc != 8) begin errors++; $display("FAIL rr_done_count got %0d required 8", dc); end
    checks++; if (byte_count !== 16'd8) begin errors++; $display("FAIL rr_byte_count got %0d required 8", byte_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_grants_left got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int tc, n;
    bit got;
    do_reset();
    sender_mode = 2;
    req_data = 32'h1312_1110;
    exp_q.push_back('{id: 2'd0, data: 8'h10});
    req_valid = 4'b0011;
    #1;
    tc = 0; n = 0; got = 0;
    while (!got && n < 200) begin
      if (tx_en) tc++;
      if (err) got = 1;
      else begin @(posedge clk); #1; n++; end
    end
    checks++; if (!got)     begin errors++; $display("FAIL timeout_err got none required pulse"); end
    checks++; if (tc != TO) begin errors++; $display("FAIL timeout_tx_en_cycles got %0d required %0d", tc, TO); end
    checks++; if (byte_count !== 16'd0) begin errors++; $display("FAIL timeout_byte_count got %0d required 0", byte_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_state got busy=%b required 0", busy); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL timeout_next_ready got %b required 0010", req_ready); end
    exp_q.push_back('{id: 2'd1, data: 8'h11});
    n = 0;
    while (!tx_en && n < 5) begin @(posedge clk); #1; n++; end
    req_valid = '0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_regrant got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_blocking();
    do_reset();
    sender_mode = 0;
    req_data = 32'h1312_1110;
    tx_status = 1'b0; en = 1'b1; req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 10; k++) begin
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL block_tx_busy got %b required 0", req_ready); end
      @(posedge clk); #1;
    end
    tx_status = 1'b1; en = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL block_en_low got %b required 0", req_ready); end
      @(posedge clk); #1;
    end
    exp_q.push_back('{id: 2'd0, data: 8'h10});
    en = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL unblock_ready got %b required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL unblock_tx_en got %b required 1", tx_en); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    sender_mode = 1; busy_len = 100;
    req_data = 32'h0000_0077;
    exp_q.push_back('{id: 2'd0, data: 8'h77});
    req_valid = 4'b0001;
    n = 0;
    while (!(busy && !tx_en && !tx_status) && n < 50) begin
      @(posedge clk); #1; n++;
      if (tx_en) req_valid = '0;
    end
    checks++; if (n >= 50) begin errors++; $display("FAIL mid_reach_wait_done got timeout required WAIT_DONE"); end
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00 || grant_id !== '0) begin
      errors++; $display("FAIL mid_reset_data got en=%b data=%h id=%0d required 0", tx_en, tx_data, grant_id); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_count !== 16'h0 || req_ready !== '0) begin
      errors++; $display("FAIL mid_reset_flags got busy=%b done=%b err=%b cnt=%h rdy=%b required 0",
                         busy, done, err, byte_count, req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_count = 16'h0000;
    n = 0;
    while (!tx_status && n < 200) begin @(posedge clk); #1; n++; end
    req_data = 32'h4433_2211;
    exp_q.push_back('{id: 2'd0, data: 8'h11});
    req_valid = 4'b1111;
    n = 0;
    while (!tx_en && n < 5) begin @(posedge clk); #1; n++; end
    req_valid = '0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_priority got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int n;
    bit got;
    do_reset();
    sender_mode = 1; busy_len = 3;
    force dut.byte_count = 16'hFFFF;
    #1;
    release dut.byte_count;
    model_count = 16'hFFFF;
    req_data = 32'h0000_0099;
    exp_q.push_back('{id: 2'd0, data: 8'h99});
    req_valid = 4'b0001;
    n = 0; got = 0;
    while (!got && n < 400) begin
      @(posedge clk); #1; n++;
      if (tx_en) req_valid = '0;
      if (done) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL wrap_done got none required pulse"); end
    checks++; if (byte_count !== 16'h0000) begin errors++; $display("FAIL wrap_byte_count got %h required 0000", byte_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_blocking();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter that shares one UART sender (8N1, `tx_status` high = idle) between up to eight byte-producing requesters. Requesters use a valid/ready handshake. The arbiter latches the granted byte and holds `tx_en` until the sender reports busy, then waits for the sender to return idle before granting again. It sits between the application byte sources and the sender, replacing the direct `tx_en = tx_status & rx_status` wiring when several sources must transmit.

## Interface
- `N`, 4: number of requesters, legal range 2..8.
- `ID_WIDTH`, 2: width of `grant_id`; must satisfy N <= 2^ID_WIDTH.
- `START_TIMEOUT`, 20000: clk cycles `tx_en` may be held without the sender going busy before the attempt is aborted; must be >= 1 and >= SEND_CLK_RATIO + 2.

Ports:
- `clk`  in  1  system clock, 100 MHz; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  1 = grants allowed; 0 = no new grants, any transfer in progress completes.
- `req_valid`  in  N  per-requester byte available.
- `req_data`  in  8*N  requester i's byte on bits [8*i+7:8*i].
- `req_ready`  out  N  one-hot accept; a transfer occurs on the clk edge where `req_valid[i] & req_ready[i]`.
- `tx_status`  in  1  sender status, 1 = idle, 0 = busy.
- `tx_en`  out  1  start request to the sender.
- `tx_data`  out  8  byte presented to the sender.
- `grant_id`  out  ID_WIDTH  index of the last accepted requester.
- `busy`  out  1  1 in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a byte completes.
- `err`  out  1  one-cycle pulse on start timeout.
- `byte_count`  out  16  count of completed bytes; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: no transfer in progress.
  - START: `tx_en` = 1.
  - WAIT_DONE: sender transmitting.
- Reset values:
  - state = IDLE; `tx_en`, `tx_data`, `done`, `err`, `byte_count` = 0.
  - `grant_id` = 0.
  - Round-robin pointer `last` = N-1, so requester 0 has first priority.
  - Reset asserted mid-transfer drops `tx_en` immediately. The byte already on the line is not tracked.
- Arbitration (combinational):
  - Active only in IDLE with `en` = 1 and `tx_status` = 1.
  - Scan the valid requesters starting at index (`last`+1) mod N, ascending with wrap.
  - The first valid requester found is winner w; `req_ready` = one-hot(w). Otherwise `req_ready` = 0.
- IDLE -> START on an accept edge:
  - `tx_data` <= `req_data[w]`.
  - `grant_id` <= w; `last` <= w.
  - `tx_en` <= 1; timeout counter <= 0.
- START:
  - If `tx_status` = 0: -> WAIT_DONE, `tx_en` <= 0.
  - Else if counter = START_TIMEOUT-1: -> IDLE, `tx_en` <= 0, `err` pulse. The byte is dropped and `byte_count` is unchanged.
  - Else: counter++.
- WAIT_DONE: when `tx_status` = 1: -> IDLE, `done` pulse, `byte_count` +1.
- `tx_data` holds its value from capture until the next capture.
- `tx_status` = 0 in IDLE (sender busy from another source) blocks all grants.
- A requester may drop `req_valid` before it is granted; no transfer occurs.
- A requester must hold `req_data` stable while valid and not ready.
- Changing `en` mid-transfer does not affect that transfer.

## Timing
- Accept edge to `tx_en` high: 1 cycle (`tx_en` is registered).
- Sender busy edge to `tx_en` low: 1 cycle, so `tx_en` is high for at least 1 cycle.
- Sender idle to `done`: `done` is high the cycle after `tx_status` is sampled 1 in WAIT_DONE; `req_ready` can assert in that same cycle.
- Earliest re-grant: 1 cycle after the sender returns idle.
- Back-to-back inter-byte gap at the sender: one send_clk period minimum, because the sender samples `tx_en` on its own tick.
- `req_ready` is combinational from `req_valid`, `state`, `en`, `tx_status` and `last`. It has no path from `req_data`.

## Test plan
- Reset, then `req_valid` = 4'b0001 with byte 0x5A; sender model goes busy 3 cycles after `tx_en` and idle 100 cycles later.
  - Required: `req_ready[0]` high for 1 cycle and `tx_data` = 0x5A.
  - Required: `tx_en` high for 4 cycles.
  - Required: `done` pulse; `byte_count` = 1, `grant_id` = 0.
- All four requesters held valid with bytes 0x10, 0x11, 0x12, 0x13 for 8 transfers.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required `tx_data` sequence matches; `byte_count` = 8.
- Sender model never goes busy, START_TIMEOUT = 50.
  - Required: `tx_en` high for exactly 50 cycles, then `err` pulse.
  - Required: `byte_count` unchanged, state IDLE, and the next requester is granted.
- `tx_status` held 0 while `req_valid` = 4'b1111; `en` = 0 while `tx_status` = 1.
  - Required: `req_ready` = 0 throughout both conditions.
  - Required: after `tx_status` returns to 1 and `en` = 1, a grant occurs within 1 cycle.
- Assert `rst` in the middle of WAIT_DONE.
  - Required: all outputs 0 without waiting for a clk edge.
  - Required: after release, requester 0 has priority.
- Preload `byte_count` to 0xFFFF with 65535 short transfers (or force it), then complete 1 more byte.
  - Required: `byte_count` = 0x0000 and `done` pulses.
